if_id_pipe: RTL and testbench

IF/ID pipeline boundary of the 5-stage MIPS core, sitting directly downstream of the fetch stage and feeding decode. Registers the fetched instruction and PC+4, holds them on a load-use hazard or an external multicycle stall, and clears them to a NOP bubble on a control-transfer flush. It also drives the PC write-enable and the decode-bubble request, and keeps a saturating stall-cycle counter for performance checks.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/if_id_pipe_if.sv | 28 ++
 rtl/lu_hazard_detect.sv | 24 ++
 rtl/if_id_pipe.sv | 96 +++++++++
 tb/tb_if_id_pipe.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, funct codes, NOP encoding and the
// IF/ID stall state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_e;

  // Instructions that read rt as a source operand (I-type ALU ops write it instead).
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/if_id_pipe_if.sv
// IF/ID boundary bundle: fetch data and hazard/stall controls in, decode-side
// registered instruction and pipeline control out.
interface if_id_pipe_if #(parameter int CNT_W = 16);

  logic [31:0]      instr_in;
  logic [31:0]      pc_incr_in;
  logic             flush;
  logic             hold_ext;
  logic             idex_mem_read;
  logic [4:0]       idex_rt;
  logic [31:0]      instr_out;
  logic [31:0]      pc_incr_out;
  logic             valid_out;
  logic             pc_write;
  logic             bubble_id;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output instr_in, pc_incr_in, flush, hold_ext, idex_mem_read, idex_rt,
    input  instr_out, pc_incr_out, valid_out, pc_write, bubble_id, stall_cnt
  );

  modport slave (
    input  instr_in, pc_incr_in, flush, hold_ext, idex_mem_read, idex_rt,
    output instr_out, pc_incr_out, valid_out, pc_write, bubble_id, stall_cnt
  );

endinterface

// File: rtl/lu_hazard_detect.sv
// Combinational load-use detector: the instruction in IF/ID reads the register
// that the load currently in ID/EX will write.
module lu_hazard_detect
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       valid_i,
  input  logic       idex_mem_read_i,
  input  logic [4:0] idex_rt_i,
  output logic       lu_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (idex_rt_i == rs_i);
  assign rt_hit = (idex_rt_i == rt_i) && uses_rt(op_i);

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign lu_o = valid_i && idex_mem_read_i && (idex_rt_i != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: 1-cycle latency; holds on hold_ext or a one-cycle
// load-use stall, flush clears to a NOP bubble and overrides both.
module if_id_pipe
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  if_id_pipe_if.slave  bus
);

  state_e           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic lu;
  logic lu_stall;
  logic freeze;
  logic pc_write;
  logic bubble;

  lu_hazard_detect u_lu (
    .op_i            (instr_q[31:26]),
    .rs_i            (instr_q[25:21]),
    .rt_i            (instr_q[20:16]),
    .valid_i         (valid_q),
    .idex_mem_read_i (bus.idex_mem_read),
    .idex_rt_i       (bus.idex_rt),
    .lu_o            (lu)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // LU_STALL always falls back to RUN, so a held instruction is never re-stalled.
  always_comb begin
    state_d = RUN;
    if (!bus.flush && !bus.hold_ext && (state_q == RUN) && lu)
      state_d = LU_STALL;
  end

  always_comb begin
    lu_stall = !bus.flush && !bus.hold_ext && (state_q == RUN) && lu;
    freeze   = !bus.flush && (bus.hold_ext || lu_stall);
    pc_write = !rst || !freeze;
    bubble   = lu_stall || !valid_q;
  end

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (bus.flush) begin
      instr_d = NOP;
      pc_d    = 32'h0;
      valid_d = 1'b0;
    end else if (!freeze) begin
      instr_d = bus.instr_in;
      pc_d    = bus.pc_incr_in;
      valid_d = (bus.instr_in != NOP);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!pc_write && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= NOP;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.instr_out   = instr_q;
  assign bus.pc_incr_out = pc_q;
  assign bus.valid_out   = valid_q;
  assign bus.pc_write    = pc_write;
  assign bus.bubble_id   = bubble;
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: directed scenarios plus randomized traffic against a
// cycle-level reference model of the IF/ID rules.
module tb_if_id_pipe;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  if_id_pipe_if #(.CNT_W(CNT_W)) ifc ();

  if_id_pipe #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents of the stage plus "the previous cycle was a load-use stall".
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_stalled;
  int          m_cnt;

  function automatic bit m_uses_rt(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
  endfunction

  function automatic bit m_lu();
    logic [4:0] rs, rt;
    rs = m_instr[25:21];
    rt = m_instr[20:16];
    return m_valid && ifc.idex_mem_read && (ifc.idex_rt != 5'd0) &&
           ((ifc.idex_rt == rs) || ((ifc.idex_rt == rt) && m_uses_rt(m_instr[31:26])));
  endfunction

  function automatic bit m_case3();
    return !ifc.flush && !ifc.hold_ext && !m_stalled && m_lu();
  endfunction

  function automatic bit m_pc_write();
    return ifc.flush || (!ifc.hold_ext && !m_case3());
  endfunction

  function automatic bit m_bubble();
    return m_case3() || !m_valid;
  endfunction

  task automatic model_reset();
    m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_stalled = 1'b0; m_cnt = 0;
  endtask

  task automatic set_in(input logic [31:0] instr, input logic [31:0] pc, input logic fl,
                        input logic hold, input logic mr, input logic [4:0] rt);
    ifc.instr_in = instr; ifc.pc_incr_in = pc; ifc.flush = fl;
    ifc.hold_ext = hold; ifc.idex_mem_read = mr; ifc.idex_rt = rt;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    bit pw, c3;
    pw = m_pc_write();
    c3 = m_case3();
    @(posedge clk);
    if (ifc.flush) begin
      m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_stalled = 1'b0;
    end else if (ifc.hold_ext) begin
      m_stalled = 1'b0;
    end else if (c3) begin
      m_stalled = 1'b1;
    end else begin
      m_instr = ifc.instr_in; m_pc = ifc.pc_incr_in;
      m_valid = (ifc.instr_in != 32'h0); m_stalled = 1'b0;
    end
    if (!pw && m_cnt < CNT_MAX) m_cnt++;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [6];
    logic [31:0] w;
    ops[0] = 6'd0; ops[1] = 6'd4; ops[2] = 6'd5; ops[3] = 6'd43; ops[4] = 6'd35; ops[5] = 6'd8;
    if ($urandom_range(0, 9) == 0) return 32'h0;
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 5)];
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(rand_instr(), 32'(4 * (i + 1)), 1'b0, 1'b0, 1'b0, 5'd0);
      tick();
    end
    set_in(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (ifc.instr_out !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", ifc.instr_out); end
    checks++; if (ifc.pc_incr_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", ifc.pc_incr_out); end
    checks++; if (ifc.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifc.valid_out); end
    checks++; if (ifc.stall_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", ifc.stall_cnt); end
    checks++; if (ifc.pc_write !== 1'b1) begin failures++; $display("FAIL reset_pc_write got=%b exp=1", ifc.pc_write); end
    checks++; if (ifc.bubble_id !== 1'b1) begin failures++; $display("FAIL reset_bubble got=%b exp=1", ifc.bubble_id); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    set_in(32'h012A4020, 32'h4, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    checks++; if (ifc.instr_out !== 32'h012A4020) begin failures++; $display("FAIL first_instr got=%h exp=012a4020", ifc.instr_out); end
    checks++; if (ifc.valid_out !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", ifc.valid_out); end
    checks++; if (ifc.pc_incr_out !== 32'h4) begin failures++; $display("FAIL first_pc got=%h exp=4", ifc.pc_incr_out); end
  endtask

  task automatic test_load_use();
    set_in(32'h01495822, 32'h8, 1'b0, 1'b0, 1'b1, 5'd9);
    #1;
    checks++; if (ifc.pc_write !== 1'b0) begin failures++; $display("FAIL lu_pc_write got=%b exp=0", ifc.pc_write); end
    checks++; if (ifc.bubble_id !== 1'b1) begin failures++; $display("FAIL lu_bubble got=%b exp=1", ifc.bubble_id); end
    tick();
    checks++; if (ifc.instr_out !== 32'h012A4020) begin failures++; $display("FAIL lu_held got=%h exp=012a4020", ifc.instr_out); end
    checks++; if (ifc.pc_write !== 1'b1) begin failures++; $display("FAIL lu_no_repeat got=%b exp=1", ifc.pc_write); end
    checks++; if (ifc.bubble_id !== 1'b0) begin failures++; $display("FAIL lu_release_bubble got=%b exp=0", ifc.bubble_id); end
    checks++; if (ifc.stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", ifc.stall_cnt); end
    tick();
    checks++; if (ifc.instr_out !== 32'h01495822) begin failures++; $display("FAIL lu_advance got=%h exp=01495822", ifc.instr_out); end
  endtask

  task automatic test_no_false_stall();
    set_in(32'h212A0005, 32'hC, 1'b0, 1'b0, 1'b1, 5'd0);
    #1;
    checks++; if (ifc.pc_write !== 1'b1) begin failures++; $display("FAIL nfs_r0 got=%b exp=1", ifc.pc_write); end
    tick();
    set_in(32'h0, 32'h10, 1'b0, 1'b0, 1'b1, 5'd10);
    #1;
    checks++; if (ifc.pc_write !== 1'b1) begin failures++; $display("FAIL nfs_addi_rt got=%b exp=1", ifc.pc_write); end
    checks++; if (ifc.bubble_id !== 1'b0) begin failures++; $display("FAIL nfs_addi_bubble got=%b exp=0", ifc.bubble_id); end
    tick();
    checks++; if (ifc.stall_cnt !== 4'd1) begin failures++; $display("FAIL nfs_cnt got=%0d exp=1", ifc.stall_cnt); end
  endtask

  task automatic test_flush();
    set_in(32'h012A4020, 32'h14, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    set_in(32'h01495822, 32'h18, 1'b1, 1'b1, 1'b1, 5'd9);
    #1;
    checks++; if (ifc.pc_write !== 1'b1) begin failures++; $display("FAIL flush_pc_write got=%b exp=1", ifc.pc_write); end
    tick();
    set_in(32'h012A4020, 32'h1C, 1'b0, 1'b0, 1'b0, 5'd0);
    checks++; if (ifc.instr_out !== 32'h0) begin failures++; $display("FAIL flush_instr got=%h exp=0", ifc.instr_out); end
    checks++; if (ifc.valid_out !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", ifc.valid_out); end
    checks++; if (ifc.bubble_id !== 1'b1) begin failures++; $display("FAIL flush_bubble got=%b exp=1", ifc.bubble_id); end
    tick();
    ifc.idex_mem_read = 1'b1; ifc.idex_rt = 5'd9;
    #1;
    checks++; if (ifc.pc_write !== 1'b0) begin failures++; $display("FAIL flush_state_run got=%b exp=0", ifc.pc_write); end
    tick();
    ifc.idex_mem_read = 1'b0;
  endtask

  task automatic test_hold_ext();
    for (int i = 0; i < 5; i++) begin
      set_in(rand_instr() | 32'h1, $urandom, 1'b0, 1'b1, 1'b0, 5'd0);
      #1;
      checks++; if (ifc.pc_write !== 1'b0) begin failures++; $display("FAIL hold_pc_write got=%b exp=0", ifc.pc_write); end
      tick();
      checks++; if (ifc.instr_out !== 32'h012A4020) begin failures++; $display("FAIL hold_frozen got=%h exp=012a4020", ifc.instr_out); end
    end
    checks++; if (ifc.stall_cnt !== 4'd7) begin failures++; $display("FAIL hold_cnt got=%0d exp=7", ifc.stall_cnt); end
    set_in(32'h212A0005, 32'h20, 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    checks++; if (ifc.pc_write !== 1'b1) begin failures++; $display("FAIL hold_release got=%b exp=1", ifc.pc_write); end
    tick();
    checks++; if (ifc.instr_out !== 32'h212A0005) begin failures++; $display("FAIL hold_resume got=%h exp=212a0005", ifc.instr_out); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      set_in($urandom, $urandom, 1'b0, 1'b1, 1'b0, 5'd0);
      tick();
      checks++; if (ifc.stall_cnt !== CNT_W'(m_cnt)) begin failures++; $display("FAIL sat_step got=%0d exp=%0d", ifc.stall_cnt, m_cnt); end
    end
    checks++; if (ifc.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_final got=%0d exp=15", ifc.stall_cnt); end
    ifc.hold_ext = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(rand_instr(), $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0),
             $urandom_range(0, 1), 5'($urandom_range(0, 3)));
      #1;
      checks++; if (ifc.pc_write !== m_pc_write()) begin failures++; $display("FAIL rnd_pc_write cyc=%0d got=%b exp=%b", i, ifc.pc_write, m_pc_write()); end
      checks++; if (ifc.bubble_id !== m_bubble()) begin failures++; $display("FAIL rnd_bubble cyc=%0d got=%b exp=%b", i, ifc.bubble_id, m_bubble()); end
      tick();
      checks++; if (ifc.instr_out !== m_instr) begin failures++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", i, ifc.instr_out, m_instr); end
      checks++; if (ifc.pc_incr_out !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, ifc.pc_incr_out, m_pc); end
      checks++; if (ifc.valid_out !== m_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, ifc.valid_out, m_valid); end
      checks++; if (ifc.stall_cnt !== CNT_W'(m_cnt)) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, ifc.stall_cnt, m_cnt); end
    end
  endtask

  initial begin
    set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    model_reset();
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_hold_ext();
    test_saturation();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
